// File: rtl/util_counter.sv
// Up/down utility counter with synchronous clear, parallel load, terminal count and wrap pulse.
// Define UTIL_COUNTER_SAT_EN to make the counter saturate at the range ends instead of wrapping.
module util_counter #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             init_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             wrap_reg;
   logic             wrap_next;
   logic [WIDTH-1:0] step_val;
   logic             at_top;
   logic             at_bot;
   logic             at_end;

   assign at_top   = (cnt_reg == '1);
   assign at_bot   = (cnt_reg == '0);
   assign at_end   = up_dn ? at_top : at_bot;
   assign step_val = up_dn ? (cnt_reg + ONE) : (cnt_reg - ONE);

`ifdef UTIL_COUNTER_SAT_EN
   // Remembers that the last enabled step was already blocked, so the pulse fires only once.
   logic sat_reg;
   logic sat_next;

   always_comb begin
      cnt_next  = cnt_reg;
      wrap_next = 1'b0;
      sat_next  = sat_reg;
      if (clr) begin
         cnt_next = INIT_VAL;
         sat_next = 1'b0;
      end else if (load) begin
         cnt_next = load_val;
         sat_next = 1'b0;
      end else if (en) begin
         if (at_end) begin
            wrap_next = ~sat_reg;
            sat_next  = 1'b1;
         end else begin
            cnt_next = step_val;
            sat_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         sat_reg <= 1'b0;
      end else begin
         sat_reg <= sat_next;
      end
   end
`else
   always_comb begin
      cnt_next  = cnt_reg;
      wrap_next = 1'b0;
      if (clr) begin
         cnt_next = INIT_VAL;
      end else if (load) begin
         cnt_next = load_val;
      end else if (en) begin
         cnt_next  = step_val;
         wrap_next = at_end;
      end
   end
`endif

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         cnt_reg  <= INIT_VAL;
         wrap_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         wrap_reg <= wrap_next;
      end
   end

   assign cnt  = cnt_reg;
   assign wrap = wrap_reg;
   // Terminal count follows up_dn combinationally, not the registered direction.
   assign tc   = at_end;

endmodule

// File: tb/tb_util_counter.sv
// Self-checking bench for util_counter: directed table, hand sequences, and random run against a model.
`timescale 1ns/100ps
module tb_util_counter;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;
`ifdef UTIL_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         init_n;
   logic         en;
   logic         clr;
   logic         load;
   logic         up_dn;
   logic [W-1:0] load_val;
   logic [W-1:0] cnt;
   logic         tc;
   logic         wrap;

   int n_checks = 0;
   int n_pass   = 0;

   util_counter #(.WIDTH(W), .INIT_VAL('0)) dut (
      .clk(clk), .init_n(init_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .cnt(cnt), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         c;
      bit         l;
      logic [3:0] lv;
      bit         e;
      bit         u;
      int         ecnt;
      bit         ewrap;
      bit         etc;
   } vec_t;

   vec_t tbl[$];

   // behavioural reference state
   int m_cnt;
   bit m_blk;
   bit m_wrap;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input bit c, input bit l, input int lv, input bit e, input bit u,
                      input int ecnt, input bit ewrap, input bit etc);
      vec_t v;
      v.c = c; v.l = l; v.lv = 4'(lv); v.e = e; v.u = u;
      v.ecnt = ecnt; v.ewrap = ewrap; v.etc = etc;
      tbl.push_back(v);
   endtask

   task automatic step(input bit c, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
      clr = c; load = l; load_val = lv; en = e; up_dn = u;
      @(posedge clk);
      #1;
      $display("t=%0t clr=%0b load=%0b lv=%0d en=%0b up=%0b -> cnt=%0d wrap=%0b tc=%0b",
               $time, c, l, lv, e, u, cnt, wrap, tc);
   endtask

   function automatic void model_edge(input bit c, input bit l, input int lv, input bit e, input bit u);
      int n;
      m_wrap = 1'b0;
      if (c) begin
         m_cnt = 0; m_blk = 1'b0;
      end else if (l) begin
         m_cnt = lv; m_blk = 1'b0;
      end else if (e) begin
         n = u ? m_cnt + 1 : m_cnt - 1;
         if (n > MAXV || n < 0) begin
            if (SAT) begin
               m_wrap = !m_blk;
               m_blk  = 1'b1;
            end else begin
               m_cnt  = (n < 0) ? MAXV : 0;
               m_wrap = 1'b1;
            end
         end else begin
            m_cnt = n; m_blk = 1'b0;
         end
      end
   endfunction

   initial begin
      bit          rc, rl, re, ru;
      logic [W-1:0] rlv;

      clr = 0; load = 0; load_val = '0; en = 1; up_dn = 1;
      init_n = 1'b1;
      #1 init_n = 1'b0;
      #1;
      check("reset_cnt", int'(cnt), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_tc", int'(tc), 0);
      init_n = 1'b1;

      // free-run through one wrap
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         $display("t=%0t free-run cnt=%0d wrap=%0b tc=%0b", $time, cnt, wrap, tc);
         check("freerun_cnt", int'(cnt), SAT ? (i + 1 > MAXV ? MAXV : i + 1) : (i + 1) % 16);
         check("freerun_wrap", int'(wrap), (i + 1 == 16) ? 1 : 0);
         check("freerun_tc", int'(tc), (SAT ? (i + 1 >= MAXV) : ((i + 1) % 16 == MAXV)) ? 1 : 0);
      end

      // asynchronous reset between edges
      step(0, 1, 4'd5, 0, 1);
      check("premid_cnt", int'(cnt), 5);
      clr = 0; load = 0; en = 1; up_dn = 1;
      #3 init_n = 1'b0;
      #1;
      check("midreset_cnt", int'(cnt), 0);
      check("midreset_wrap", int'(wrap), 0);
      init_n = 1'b1;
      step(0, 0, 4'd0, 1, 1);
      check("restart1_cnt", int'(cnt), 1);
      step(0, 0, 4'd0, 1, 1);
      check("restart2_cnt", int'(cnt), 2);

      // directed table
      add(1, 1, 9, 0, 1, 0, 0, 0);
      add(0, 1, 9, 0, 1, 9, 0, 0);
      add(0, 1, 9, 1, 1, 9, 0, 0);
      add(0, 1, 1, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, SAT ? 0 : 15, 1, SAT ? 1 : 0);
      add(0, 0, 0, 1, 0, SAT ? 0 : 14, 0, SAT ? 1 : 0);
      add(0, 1, 7, 0, 0, 7, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 3, 0, 0, 7, 0, 0);
      add(0, 1, 15, 1, 1, 15, 0, 1);
      add(0, 0, 0, 1, 1, SAT ? 15 : 0, 1, SAT ? 1 : 0);
      add(1, 0, 5, 1, 0, 0, 0, 1);
      foreach (tbl[i]) begin
         step(tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].u);
         check($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].ecnt);
         check($sformatf("tbl%0d_wrap", i), int'(wrap), int'(tbl[i].ewrap));
         check($sformatf("tbl%0d_tc", i), int'(tc), int'(tbl[i].etc));
      end

      // tc follows up_dn without a clock edge (cnt is 0 here)
      en = 0; up_dn = 1;
      #1;
      check("tc_dir_up", int'(tc), 0);
      up_dn = 0;
      #1;
      check("tc_dir_dn", int'(tc), 1);

`ifdef UTIL_COUNTER_SAT_EN
      step(0, 1, 4'd14, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 4'd0, 1, 1);
         check("sat_cnt", int'(cnt), 15);
         check("sat_wrap", int'(wrap), (i == 1) ? 1 : 0);
      end
`endif

      // randomized run against the reference model
      step(1, 0, 4'd0, 0, 1);
      m_cnt = 0; m_blk = 1'b0;
      ru = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rc  = ($urandom % 20) == 0;
         rl  = ($urandom % 8) == 0;
         rlv = W'($urandom);
         re  = ($urandom % 4) != 0;
         if (($urandom % 10) == 0) ru = ~ru;
         model_edge(rc, rl, int'(rlv), re, ru);
         step(rc, rl, rlv, re, ru);
         check("rand_cnt", int'(cnt), m_cnt);
         check("rand_wrap", int'(wrap), int'(m_wrap));
         check("rand_tc", int'(tc), (ru ? (m_cnt == MAXV) : (m_cnt == 0)) ? 1 : 0);
         if (($urandom % 40) == 0) begin
            #2 init_n = 1'b0;
            #1;
            check("rand_reset_cnt", int'(cnt), 0);
            check("rand_reset_wrap", int'(wrap), 0);
            init_n = 1'b1;
            m_cnt = 0; m_blk = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
